// File: rtl/expipe_pkg.sv
// -----------------------------------------------------------------------------
// expipe_pkg
//   Types and widths shared by the execution-pipeline blocks.
//   - ROB_IDX_W / rob_idx_t : reorder-buffer index carried with every destination
//   - REGSTAT_CNT_W         : width of the per-register in-flight writer counter
//   - regstat_entry_t       : one register-status table entry {cnt, last_rob}
//                             at the default counter width
// -----------------------------------------------------------------------------
package expipe_pkg;

    localparam int ROB_IDX_W     = 4;
    localparam int REGSTAT_CNT_W = 2;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;

    typedef struct packed {
        logic [REGSTAT_CNT_W-1:0] cnt;
        rob_idx_t                 last_rob;
    } regstat_entry_t;

endpackage : expipe_pkg

// File: rtl/regstat_table.sv
// -----------------------------------------------------------------------------
// regstat_table
//   Register status (scoreboard) table. For every architectural register it
//   keeps the number of in-flight writers and the ROB index of the youngest
//   writer, so operand lookup can tell whether a source is still being produced
//   and by which ROB entry.
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-high reset
//   flush_i             : clears every in-flight count (mispredict / exception)
//   issue_valid_i/ready_o, issue_rd_idx_i, issue_rob_idx_i
//                       : destination allocation handshake
//   comm_valid_i, comm_rd_idx_i
//                       : commit release of a destination (always accepted)
//   rs_idx_i[k]         : operand lookup index, k = 0..NUM_RS-1
//   rs_busy_o[k]        : register has at least one in-flight writer
//   rs_rob_idx_o[k]     : ROB index of the youngest writer (held when idle)
//   underflow_o         : sticky, set by a commit to a non-busy register
// -----------------------------------------------------------------------------
module regstat_table
    import expipe_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int CNT_W     = REGSTAT_CNT_W,
    parameter int NUM_RS    = 2,
    parameter int SKIP_ZERO = 1,
    localparam int IDX_W    = $clog2(NREG)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           issue_valid_i,
    output logic                           issue_ready_o,
    input  logic [IDX_W-1:0]               issue_rd_idx_i,
    input  rob_idx_t                       issue_rob_idx_i,
    input  logic                           comm_valid_i,
    input  logic [IDX_W-1:0]               comm_rd_idx_i,
    input  logic [NUM_RS-1:0][IDX_W-1:0]   rs_idx_i,
    output logic [NUM_RS-1:0]              rs_busy_o,
    output rob_idx_t [NUM_RS-1:0]          rs_rob_idx_o,
    output logic                           underflow_o
);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        rob_idx_t         last_rob;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    entry_t tbl_q [NREG];
    entry_t tbl_d [NREG];
    logic   underflow_q;
    logic   underflow_d;

    logic issue_skip;
    logic comm_skip;
    logic issue_full;
    logic comm_same_rd;
    logic issue_fire;
    logic comm_fire;

    // Register 0 of the integer file is hard-wired and never tracked.
    assign issue_skip   = (SKIP_ZERO != 0) && (issue_rd_idx_i == '0);
    assign comm_skip    = (SKIP_ZERO != 0) && (comm_rd_idx_i == '0);

    // A saturated counter can still accept an issue if a commit to the same
    // register frees a slot in the same cycle; flush discards everything, so
    // the issue side never has to stall while it is asserted.
    assign issue_full   = (tbl_q[issue_rd_idx_i].cnt == CNT_MAX);
    assign comm_same_rd = comm_valid_i && (comm_rd_idx_i == issue_rd_idx_i);
    assign issue_ready_o = flush_i || !issue_full || comm_same_rd;

    assign issue_fire   = issue_valid_i && issue_ready_o && !issue_skip;
    assign comm_fire    = comm_valid_i && !comm_skip;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            tbl_d[r] = tbl_q[r];
        end
        underflow_d = underflow_q;

        if (flush_i) begin
            for (int r = 0; r < NREG; r++) begin
                tbl_d[r].cnt = '0;
            end
        end else if (issue_fire && comm_fire && (issue_rd_idx_i == comm_rd_idx_i)) begin
            // One writer in, one out: count is unchanged, youngest writer moves.
            tbl_d[issue_rd_idx_i].last_rob = issue_rob_idx_i;
        end else begin
            if (issue_fire) begin
                tbl_d[issue_rd_idx_i].cnt      = tbl_q[issue_rd_idx_i].cnt + CNT_W'(1);
                tbl_d[issue_rd_idx_i].last_rob = issue_rob_idx_i;
            end
            if (comm_fire) begin
                if (tbl_q[comm_rd_idx_i].cnt == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    tbl_d[comm_rd_idx_i].cnt = tbl_q[comm_rd_idx_i].cnt - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                tbl_q[r] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                tbl_q[r] <= tbl_d[r];
            end
            underflow_q <= underflow_d;
        end
    end

    assign underflow_o = underflow_q;

    // Lookups read registered state only: an issue is not visible until the
    // following cycle.
    for (genvar k = 0; k < NUM_RS; k++) begin : g_rs
        assign rs_busy_o[k]    = (tbl_q[rs_idx_i[k]].cnt != '0);
        assign rs_rob_idx_o[k] = tbl_q[rs_idx_i[k]].last_rob;
    end

endmodule : regstat_table
